// File: rtl/bus_arb_fabric_if.sv
// Bus bundle for bus_arb_fabric: master-side request/response signals and
// slave-side select/response signals, each seen from the fabric.
interface bus_arb_fabric_if #(
  parameter int NM = 4,
  parameter int NS = 8,
  parameter int AW = 30,
  parameter int DW = 32
);
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_grnt;
  logic [NM*AW-1:0] m_addr;
  logic [NM-1:0]    m_as;
  logic [NM-1:0]    m_rw;
  logic [NM*DW-1:0] m_wdata;
  logic             m_ready;
  logic             m_err;
  logic [DW-1:0]    m_rdata;

  logic [NS-1:0]    s_cs;
  logic [AW-1:0]    s_addr;
  logic             s_as;
  logic             s_rw;
  logic [DW-1:0]    s_wdata;
  logic [NS-1:0]    s_ready;
  logic [NS*DW-1:0] s_rdata;

  // Port where the bus masters attach to the fabric.
  modport master (
    input  m_req, m_addr, m_as, m_rw, m_wdata,
    output m_grnt, m_ready, m_err, m_rdata
  );

  // Port where the fabric drives the slaves.
  modport slave (
    output s_cs, s_addr, s_as, s_rw, s_wdata,
    input  s_ready, s_rdata
  );
endinterface

// File: rtl/bus_arb_fabric.sv
// Round-robin multi-master bus fabric: non-preemptive arbiter, owner mux,
// address decoder, decode-error and timeout termination.
module bus_arb_fabric #(
  parameter int NM      = 4,
  parameter int NS      = 8,
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  bus_arb_fabric_if.master mst_if,
  bus_arb_fabric_if.slave  slv_if
);

  localparam int IW = $clog2(NM);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [NM-1:0] grnt_q,  grnt_d;
  logic [IW-1:0] own_q,   own_d;
  logic [IW-1:0] last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          abort_q, abort_d;
  logic          derr_q,  derr_d;

  logic          owned;
  logic          hold;
  logic          rr_found;
  logic [IW-1:0] rr_pick;
  logic [IW-1:0] cand;

  logic          o_as;
  logic          o_rw;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata;
  logic          as_gated;

  logic [SEL_W-1:0] idx;
  logic             idx_ok;
  logic [NS-1:0]    cs;
  logic             nrdy;
  logic [DW-1:0]    rdata;
  logic             rdy_any;

  assign owned = (state_q == ST_OWNED);
  assign hold  = owned && mst_if.m_req[own_q];

  // Round-robin search starting one past the last owner.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_q;
    cand     = '0;
    for (int unsigned k = 1; k <= NM; k++) begin
      cand = IW'((32'(last_q) + k) % NM);
      if (!rr_found && mst_if.m_req[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grnt_d  = grnt_q;
    own_d   = own_q;
    last_d  = last_q;
    if (!hold) begin
      if (rr_found) begin
        state_d = ST_OWNED;
        own_d   = rr_pick;
        last_d  = rr_pick;
        grnt_d  = NM'(1) << rr_pick;
      end else begin
        state_d = ST_IDLE;
        grnt_d  = '0;
      end
    end
  end

  always_comb begin
    o_as    = 1'b0;
    o_rw    = 1'b0;
    o_addr  = '0;
    o_wdata = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (grnt_q[i]) begin
        o_as    = mst_if.m_as[i];
        o_rw    = mst_if.m_rw[i];
        o_addr  = mst_if.m_addr[i*AW +: AW];
        o_wdata = mst_if.m_wdata[i*DW +: DW];
      end
    end
  end

  assign as_gated = o_as & ~abort_q;
  assign idx      = o_addr[AW-1 -: SEL_W];
  assign idx_ok   = int'(idx) < NS;

  always_comb begin
    cs    = '0;
    nrdy  = 1'b0;
    rdata = '0;
    for (int unsigned j = 0; j < NS; j++) begin
      if (as_gated && idx == SEL_W'(j)) begin
        cs[j] = 1'b1;
        if (slv_if.s_ready[j]) begin
          nrdy  = 1'b1;
          rdata = slv_if.s_rdata[j*DW +: DW];
        end
      end
    end
  end

  // A completion in the cycle the counter reaches its limit cancels the abort.
  assign rdy_any = nrdy | derr_q;

  always_comb begin
    if (!hold || !as_gated || rdy_any) begin
      cnt_d = '0;
    end else if (cnt_q != TMO) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
    abort_d = hold && as_gated && !rdy_any && (cnt_q == TMO);
    derr_d  = hold && as_gated && !idx_ok && !derr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grnt_q  <= '0;
      own_q   <= '0;
      last_q  <= IW'(NM - 1);
      cnt_q   <= '0;
      abort_q <= 1'b0;
      derr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grnt_q  <= grnt_d;
      own_q   <= own_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      derr_q  <= derr_d;
    end
  end

  assign mst_if.m_grnt  = grnt_q;
  assign mst_if.m_ready = owned & (nrdy | derr_q | abort_q);
  assign mst_if.m_err   = owned & (derr_q | abort_q);
  assign mst_if.m_rdata = rdata;

  assign slv_if.s_cs    = cs;
  assign slv_if.s_addr  = o_addr;
  assign slv_if.s_as    = as_gated;
  assign slv_if.s_rw    = o_rw;
  assign slv_if.s_wdata = o_wdata;

endmodule

// File: tb/tb_bus_arb_fabric.sv
// Directed and randomized checks of bus_arb_fabric against a cycle-level
// behavioural model of the arbitration and response rules.
module tb_bus_arb_fabric;
  localparam int NM      = 4;
  localparam int NS      = 6;
  localparam int AW      = 30;
  localparam int DW      = 32;
  localparam int SEL_W   = 3;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arb_fabric_if #(.NM(NM), .NS(NS), .AW(AW), .DW(DW)) bus ();

  bus_arb_fabric #(
    .NM(NM), .NS(NS), .AW(AW), .DW(DW), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mst_if (bus),
    .slv_if (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  // Model state: current owner (-1 = none), last owner, wait count, flags.
  int mo_own;
  int mo_last;
  int mo_cnt;
  bit mo_abort;
  bit mo_derr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mo_own   = -1;
    mo_last  = NM - 1;
    mo_cnt   = 0;
    mo_abort = 1'b0;
    mo_derr  = 1'b0;
  endtask

  task automatic set_m(input int i, input logic req, input logic as, input logic rw,
                       input logic [AW-1:0] addr);
    bus.m_req[i]              = req;
    bus.m_as[i]               = as;
    bus.m_rw[i]               = rw;
    bus.m_addr[i*AW +: AW]    = addr;
    bus.m_wdata[i*DW +: DW]   = $urandom;
  endtask

  // At the falling edge: compare every output with the model, then advance it.
  task automatic cyc_eval();
    bit            owned, as_o, nrdy, rdy, hold;
    logic [AW-1:0] addr;
    int            idx, c;
    @(negedge clk);
    owned = (mo_own >= 0);
    addr  = owned ? bus.m_addr[mo_own*AW +: AW] : '0;
    as_o  = owned && bus.m_as[mo_own] && !mo_abort;
    idx   = int'(addr >> (AW - SEL_W));
    nrdy  = as_o && (idx < NS) && bus.s_ready[idx];
    rdy   = owned && (nrdy || mo_derr || mo_abort);

    chk("grnt",    bus.m_grnt, owned ? (64'd1 << mo_own) : 64'd0);
    chk("s_as",    bus.s_as, as_o);
    chk("s_cs",    bus.s_cs, (as_o && idx < NS) ? (64'd1 << idx) : 64'd0);
    chk("s_addr",  bus.s_addr, addr);
    chk("s_rw",    bus.s_rw, owned ? bus.m_rw[mo_own] : 1'b0);
    chk("s_wdata", bus.s_wdata, owned ? bus.m_wdata[mo_own*DW +: DW] : '0);
    chk("m_ready", bus.m_ready, rdy);
    chk("m_err",   bus.m_err, owned && (mo_derr || mo_abort));
    chk("m_rdata", bus.m_rdata, nrdy ? bus.s_rdata[idx*DW +: DW] : '0);

    hold     = owned && bus.m_req[mo_own];
    mo_abort = hold && as_o && !rdy && (mo_cnt == TIMEOUT);
    mo_derr  = hold && as_o && (idx >= NS) && !mo_derr;
    if (!hold || !as_o || rdy) mo_cnt = 0;
    else if (mo_cnt < TIMEOUT) mo_cnt++;
    if (!hold) begin
      mo_own = -1;
      for (int k = 1; k <= NM; k++) begin
        c = (mo_last + k) % NM;
        if (mo_own < 0 && bus.m_req[c]) mo_own = c;
      end
      if (mo_own >= 0) mo_last = mo_own;
    end
  endtask

  task automatic cyc_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    cyc_eval();
    cyc_edge();
  endtask

  task automatic go_idle();
    bus.m_req   = '0;
    bus.m_as    = '0;
    bus.s_ready = '0;
    cyc();
    cyc();
  endtask

  initial begin
    bus.m_req   = '0;
    bus.m_as    = '0;
    bus.m_rw    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.s_ready = '0;
    bus.s_rdata = '0;
    model_reset();

    // Reset state, including with requests pending across a clock edge.
    #2;
    chk("rst_grnt", bus.m_grnt, 0);
    chk("rst_s_as", bus.s_as, 0);
    chk("rst_s_cs", bus.s_cs, 0);
    chk("rst_ready", bus.m_ready, 0);
    chk("rst_err", bus.m_err, 0);
    chk("rst_rdata", bus.m_rdata, 0);
    bus.m_req = 4'b1111;
    cyc_edge();
    chk("rst_hold_grnt", bus.m_grnt, 0);
    rst = 1'b0;

    // Round robin: all masters request on slave 1, owner drops for one cycle.
    for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b1, 1'b0, 30'h0800_0000 | 30'(i));
    bus.s_ready = 6'b000010;
    bus.s_rdata[1*DW +: DW] = 32'h1234_5678;
    cyc();
    chk("rr_grant0", bus.m_grnt, 4'b0001);
    for (int n = 0; n < 5; n++) begin
      int own = n % NM;
      cyc_eval();
      chk("rr_done", bus.m_ready, 1'b1);
      cyc_edge();
      bus.m_req[own] = 1'b0;
      cyc();
      chk("rr_grant", bus.m_grnt, 64'd1 << ((own + 1) % NM));
      bus.m_req[own] = 1'b1;
    end
    go_idle();

    // Read by master 2 from slave 2 (top three address bits = 3'b010).
    set_m(2, 1'b1, 1'b1, 1'b1, 30'h1000_0010);
    bus.s_rdata[2*DW +: DW] = 32'hDEAD_BEEF;
    cyc();
    chk("rd_grant", bus.m_grnt, 4'b0100);
    for (int w = 0; w < 3; w++) begin
      cyc_eval();
      chk("rd_cs", bus.s_cs, 6'b000100);
      chk("rd_wait", bus.m_ready, 1'b0);
      cyc_edge();
    end
    bus.s_ready[2] = 1'b1;
    cyc_eval();
    chk("rd_ready", bus.m_ready, 1'b1);
    chk("rd_data", bus.m_rdata, 32'hDEAD_BEEF);
    chk("rd_err", bus.m_err, 1'b0);
    cyc_edge();
    go_idle();

    // Decode error: slave index 7 with only six slaves.
    set_m(1, 1'b1, 1'b1, 1'b0, 30'h3800_0000);
    cyc();
    cyc_eval();
    chk("de_cs", bus.s_cs, 0);
    chk("de_first", bus.m_ready, 1'b0);
    cyc_edge();
    cyc_eval();
    chk("de_ready", bus.m_ready, 1'b1);
    chk("de_err", bus.m_err, 1'b1);
    chk("de_cs2", bus.s_cs, 0);
    cyc_edge();
    cyc_eval();
    chk("de_once_r", bus.m_ready, 1'b0);
    chk("de_once_e", bus.m_err, 1'b0);
    cyc_edge();
    go_idle();

    // Timeout: slave 3 never ready, error on the sixth cycle of s_as.
    set_m(3, 1'b1, 1'b1, 1'b1, 30'h1800_0000);
    cyc();
    for (int c = 1; c <= 5; c++) begin
      cyc_eval();
      chk("to_wait_as", bus.s_as, 1'b1);
      chk("to_wait_err", bus.m_err, 1'b0);
      cyc_edge();
    end
    cyc_eval();
    chk("to_err", bus.m_err, 1'b1);
    chk("to_ready", bus.m_ready, 1'b1);
    chk("to_as", bus.s_as, 1'b0);
    chk("to_cs", bus.s_cs, 0);
    cyc_edge();
    cyc_eval();
    chk("to_clear", bus.m_err, 1'b0);
    chk("to_as_back", bus.s_as, 1'b1);
    cyc_edge();
    go_idle();

    // Race: ready arrives in the cycle the wait count reaches the limit.
    set_m(3, 1'b1, 1'b1, 1'b0, 30'h1800_0004);
    cyc();
    for (int c = 1; c <= 4; c++) cyc();
    bus.s_ready[3] = 1'b1;
    cyc_eval();
    chk("race_ready", bus.m_ready, 1'b1);
    chk("race_err", bus.m_err, 1'b0);
    cyc_edge();
    bus.s_ready[3] = 1'b0;
    cyc_eval();
    chk("race_no_abort", bus.m_err, 1'b0);
    cyc_edge();
    go_idle();

    // Asynchronous reset pulse in the middle of a read.
    set_m(2, 1'b1, 1'b1, 1'b1, 30'h1000_0010);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("arst_grnt", bus.m_grnt, 0);
    chk("arst_cs", bus.s_cs, 0);
    chk("arst_as", bus.s_as, 0);
    model_reset();
    #1;
    rst = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b0, 30'h0000_0040);
    cyc();
    chk("arst_first", bus.m_grnt, 4'b0001);
    go_idle();

    // Randomized traffic with sticky requests and sparse slave readiness.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(0, 5) == 0) bus.m_req[i] = ~bus.m_req[i];
        bus.m_as[i] = ($urandom_range(0, 4) != 0);
        bus.m_rw[i] = 1'($urandom);
        bus.m_addr[i*AW +: AW] = {3'($urandom_range(0, 7)), 27'($urandom)};
        bus.m_wdata[i*DW +: DW] = $urandom;
      end
      for (int j = 0; j < NS; j++) begin
        bus.s_ready[j] = ($urandom_range(0, 5) == 0);
        bus.s_rdata[j*DW +: DW] = $urandom;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
